// File: rtl/queue_ctrl.sv
// Ticket-queue sequencer: owns issued/current/waiting counters and the IDLE/CALL/SERVE FSM.
// Request edges sampled at posedge n act at posedge n+1; every output is registered.
module queue_ctrl #(
  parameter int TICKET_MAX = 63,
  parameter int WAT_MAX    = 20,
  parameter int CALL_CMAX  = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
  input  logic       serve,
  input  logic       done,
  output logic [5:0] u_tot,
  output logic [5:0] u_cur,
  output logic [5:0] u_wat,
  output logic       calling,
  output logic       busy,
  output logic       full,
  output logic       rej
);
  localparam int TW = $clog2(CALL_CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALL  = 2'd1,
    S_SERVE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [2:0]    r_lvl_q;
  logic [2:0]    r_lvl_qq;
  logic          w_take_e;
  logic          w_serve_e;
  logic          w_done_e;
  logic          w_take_ok;
  logic          w_serve_ok;
  logic          w_rej_nxt;
  logic [5:0]    w_tot_nxt;
  logic [5:0]    w_cur_nxt;
  logic [5:0]    w_wat_nxt;

  function automatic logic [5:0] f_next_ticket(input logic [5:0] t);
    return (t == 6'(TICKET_MAX)) ? 6'd1 : t + 6'd1;
  endfunction

  // Level history keeps sampling through reset so a request held across reset is not an edge.
  always_ff @(posedge clk) begin
    r_lvl_q  <= {take, serve, done};
    r_lvl_qq <= r_lvl_q;
  end

  assign w_take_e   = r_lvl_q[2] & ~r_lvl_qq[2];
  assign w_serve_e  = r_lvl_q[1] & ~r_lvl_qq[1];
  assign w_done_e   = r_lvl_q[0] & ~r_lvl_qq[0];
  assign w_take_ok  = w_take_e && (u_wat < 6'(WAT_MAX));
  assign w_serve_ok = w_serve_e && (u_wat != 6'd0) && (r_state != S_CALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      u_tot   <= '0;
      u_cur   <= '0;
      u_wat   <= '0;
      calling <= 1'b0;
      busy    <= 1'b0;
      full    <= 1'b0;
      rej     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      u_tot   <= w_tot_nxt;
      u_cur   <= w_cur_nxt;
      u_wat   <= w_wat_nxt;
      calling <= (w_state_nxt == S_CALL);
      busy    <= (w_state_nxt != S_IDLE);
      full    <= (w_wat_nxt == 6'(WAT_MAX));
      rej     <= w_rej_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_serve_ok) w_state_nxt = S_CALL;
      S_CALL:  if (r_timer == '0) w_state_nxt = S_SERVE;
      S_SERVE: if (w_serve_ok) w_state_nxt = S_CALL;
               else if (w_done_e) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Take and serve both judge against the pre-cycle count; done is only legal in SERVE.
  always_comb begin
    w_tot_nxt   = w_take_ok ? f_next_ticket(u_tot) : u_tot;
    w_cur_nxt   = w_serve_ok ? f_next_ticket(u_cur) : u_cur;
    w_wat_nxt   = u_wat + {5'd0, w_take_ok} - {5'd0, w_serve_ok};
    w_timer_nxt = r_timer;
    if (w_serve_ok)
      w_timer_nxt = TW'(CALL_CMAX - 1);
    else if ((r_state == S_CALL) && (r_timer != '0))
      w_timer_nxt = r_timer - TW'(1);
    w_rej_nxt = (w_take_e && !w_take_ok) ||
                (w_serve_e && !w_serve_ok) ||
                (w_done_e && (r_state != S_SERVE));
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Bench for queue_ctrl: two instances with different limits share stimulus and are
// compared every cycle against a queue-of-tickets reference model plus directed constants.
module tb_queue_ctrl;
  localparam int TM0 = 63, WM0 = 20, CM0 = 4;
  localparam int TM1 = 3,  WM1 = 2,  CM1 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       take = 1'b0;
  logic       serve = 1'b0;
  logic       done = 1'b0;
  logic [5:0] o_tot [2];
  logic [5:0] o_cur [2];
  logic [5:0] o_wat [2];
  logic       o_calling [2];
  logic       o_busy [2];
  logic       o_full [2];
  logic       o_rej [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  queue_ctrl #(.TICKET_MAX(TM0), .WAT_MAX(WM0), .CALL_CMAX(CM0)) u_dut0 (
    .clk(clk), .rst(rst), .take(take), .serve(serve), .done(done),
    .u_tot(o_tot[0]), .u_cur(o_cur[0]), .u_wat(o_wat[0]),
    .calling(o_calling[0]), .busy(o_busy[0]), .full(o_full[0]), .rej(o_rej[0])
  );

  queue_ctrl #(.TICKET_MAX(TM1), .WAT_MAX(WM1), .CALL_CMAX(CM1)) u_dut1 (
    .clk(clk), .rst(rst), .take(take), .serve(serve), .done(done),
    .u_tot(o_tot[1]), .u_cur(o_cur[1]), .u_wat(o_wat[1]),
    .calling(o_calling[1]), .busy(o_busy[1]), .full(o_full[1]), .rej(o_rej[1])
  );

  // Reference model: waiting tickets held as a literal queue; mode 0 idle, 1 call, 2 serve.
  int       m_q0 [$];
  int       m_q1 [$];
  int       m_tot [2];
  int       m_cur [2];
  int       m_mode [2];
  int       m_left [2];
  int       m_rej [2];
  bit [2:0] m_s1 [2];
  bit [2:0] m_s2 [2];

  function automatic int msize(input int k);
    return (k == 0) ? m_q0.size() : m_q1.size();
  endfunction

  task automatic model_tick(input int k);
    int q [$];
    int tmx, wmx, cmx, wat0;
    bit te, se, de, tok, sok;
    tmx = (k == 0) ? TM0 : TM1;
    wmx = (k == 0) ? WM0 : WM1;
    cmx = (k == 0) ? CM0 : CM1;
    if (k == 0) q = m_q0; else q = m_q1;
    te = m_s1[k][2] && !m_s2[k][2];
    se = m_s1[k][1] && !m_s2[k][1];
    de = m_s1[k][0] && !m_s2[k][0];
    m_s2[k] = m_s1[k];
    m_s1[k] = {take, serve, done};
    if (rst) begin
      q.delete();
      m_tot[k] = 0; m_cur[k] = 0; m_mode[k] = 0; m_left[k] = 0; m_rej[k] = 0;
    end else begin
      wat0 = q.size();
      m_rej[k] = 0;
      sok = se && (wat0 > 0) && (m_mode[k] != 1);
      tok = te && (wat0 < wmx);
      if (te && !tok) m_rej[k] = 1;
      if (se && !sok) m_rej[k] = 1;
      case (m_mode[k])
        1: begin
          if (de) m_rej[k] = 1;
          m_left[k]--;
          if (m_left[k] == 0) m_mode[k] = 2;
        end
        0: if (de) m_rej[k] = 1;
        default: if (!sok && de) m_mode[k] = 0;
      endcase
      if (sok) begin
        m_cur[k] = q.pop_front();
        m_mode[k] = 1;
        m_left[k] = cmx;
      end
      if (tok) begin
        m_tot[k] = (m_tot[k] == tmx) ? 1 : m_tot[k] + 1;
        q.push_back(m_tot[k]);
      end
    end
    if (k == 0) m_q0 = q; else m_q1 = q;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int wmx;
    for (int k = 0; k < 2; k++) begin
      wmx = (k == 0) ? WM0 : WM1;
      chk($sformatf("m%0d_tot", k), o_tot[k], m_tot[k]);
      chk($sformatf("m%0d_cur", k), o_cur[k], m_cur[k]);
      chk($sformatf("m%0d_wat", k), o_wat[k], msize(k));
      chk($sformatf("m%0d_calling", k), o_calling[k], (m_mode[k] == 1) ? 1 : 0);
      chk($sformatf("m%0d_busy", k), o_busy[k], (m_mode[k] != 0) ? 1 : 0);
      chk($sformatf("m%0d_full", k), o_full[k], (msize(k) == wmx) ? 1 : 0);
      chk($sformatf("m%0d_rej", k), o_rej[k], m_rej[k]);
    end
  endtask

  task automatic cyc(input logic t, input logic s, input logic d, input logic r);
    take = t; serve = s; done = d; rst = r;
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    #1 compare_all();
  endtask

  task automatic pulse(input logic t, input logic s, input logic d);
    cyc(t, s, d, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    repeat (3) cyc(0, 0, 0, 1);
    chk("rst_tot", o_tot[0], 0);
    chk("rst_busy", o_busy[0], 0);
    chk("rst_rej", o_rej[0], 0);
    cyc(0, 0, 0, 0);

    for (int i = 1; i <= 3; i++) begin
      pulse(1, 0, 0);
      chk("take_tot", o_tot[0], i);
      chk("take_wat", o_wat[0], i);
      chk("take_cur", o_cur[0], 0);
      chk("take_rej", o_rej[0], 0);
    end
    chk("full_rej", o_rej[1], 1);
    chk("full_tot", o_tot[1], 2);
    chk("full_flag", o_full[1], 1);

    pulse(0, 1, 0);
    chk("srv_cur", o_cur[0], 1);
    chk("srv_wat", o_wat[0], 2);
    chk("srv_calling", o_calling[0], 1);
    n = 0;
    while (o_calling[0] === 1'b1 && n < 20) begin
      n++;
      cyc(0, 0, 0, 0);
    end
    chk("call_len", n, CM0);
    chk("serve_busy", o_busy[0], 1);
    chk("serve_calling", o_calling[0], 0);

    pulse(0, 1, 0);
    chk("adv_cur", o_cur[0], 2);
    chk("adv_wat", o_wat[0], 1);
    pulse(0, 1, 0);
    chk("call_srv_rej", o_rej[0], 1);
    chk("call_srv_cur", o_cur[0], 2);
    chk("call_still", o_calling[0], 1);
    repeat (4) cyc(0, 0, 0, 0);
    chk("serve2_busy", o_busy[0], 1);
    pulse(0, 0, 1);
    chk("done_busy", o_busy[0], 0);
    chk("done_cur", o_cur[0], 2);
    chk("done_rej", o_rej[0], 0);

    pulse(1, 1, 0);
    chk("ts_tot", o_tot[1], 3);
    chk("ts_wat", o_wat[1], 1);
    chk("ts_rej", o_rej[1], 1);
    chk("ts_busy", o_busy[1], 0);
    chk("ts_both_wat", o_wat[0], 1);
    chk("ts_both_cur", o_cur[0], 3);

    pulse(1, 0, 0);
    chk("wrap_tot", o_tot[1], 1);
    chk("wrap_full", o_full[1], 1);
    pulse(1, 1, 0);
    chk("fs_cur", o_cur[1], 3);
    chk("fs_wat", o_wat[1], 1);
    chk("fs_rej", o_rej[1], 1);
    chk("fs_tot", o_tot[1], 1);

    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hold_tot", o_tot[0], 7);

    pulse(0, 1, 0);
    chk("pre_rst_call", o_calling[0], 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("mid_rst_tot", o_tot[0], 0);
    chk("mid_rst_cur", o_cur[0], 0);
    chk("mid_rst_wat", o_wat[0], 0);
    chk("mid_rst_calling", o_calling[0], 0);
    chk("mid_rst_busy", o_busy[0], 0);
    chk("mid_rst_rej", o_rej[0], 0);
    repeat (3) cyc(1, 0, 0, 0);
    chk("rst_hold_tot", o_tot[0], 0);
    chk("rst_hold_wat", o_wat[0], 0);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 2, $urandom_range(0, 199) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
